// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle ops and an optional shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multi-cycle multiply (Function 110).
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset_b,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         Function,
    input  logic               start,
    input  logic               use_reg,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] ALUout
);
    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    r_alu;
    logic             r_done;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic [W2-1:0]    w_result;
    logic [W2-1:0]    w_mul_res;

    assign w_accept = start & ~busy;
    assign w_bop    = use_reg ? r_alu[WIDTH-1:0] : B;

    // Ripple-carry chain of full-adder cells
    assign w_c[0] = 1'b0;
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign w_sum[g]   = A[g] ^ w_bop[g] ^ w_c[g];
        assign w_c[g+1]   = (A[g] & w_bop[g]) | (w_c[g] & (A[g] ^ w_bop[g]));
    end

    always_comb begin
        w_result = r_alu;
        unique case (Function)
            3'b000: w_result = {{(WIDTH-1){1'b0}}, w_c[WIDTH], w_sum};
            3'b001: w_result = {{WIDTH{1'b0}}, A} - {{WIDTH{1'b0}}, w_bop};
            3'b010: w_result = {{WIDTH{w_bop[WIDTH-1]}}, w_bop};
            3'b011: w_result = {{(W2-1){1'b0}}, |{A, w_bop}};
            3'b100: w_result = {{(W2-1){1'b0}}, &{A, w_bop}};
            3'b101: w_result = {A, w_bop};
            3'b110: w_result = '0;
            3'b111: w_result = r_alu;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W2-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [W2-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    w_pp;

    assign busy        = (r_state == S_MUL);
    assign w_mul_start = w_accept & (Function == 3'b110);
    assign w_pp        = r_mplier[0] ? r_mcand : '0;
    assign w_mul_res   = r_acc + w_pp;

    always_ff @(posedge Clock) begin
        if (!Reset_b) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_mul_last = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_mul_start) w_next = S_MUL;
            S_MUL: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next     = S_IDLE;
                    w_mul_last = 1'b1;
                end
            end
        endcase
    end

    // One partial product per cycle, LSB of multiplier first
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= w_bop;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (busy) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_mul_res;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
`else
    assign busy        = 1'b0;
    assign w_mul_start = 1'b0;
    assign w_mul_last  = 1'b0;
    assign w_mul_res   = '0;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            r_alu  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_mul_last) begin
                r_alu  <= w_mul_res;
                r_done <= 1'b1;
            end else if (w_accept && !w_mul_start) begin
                r_alu  <= w_result;
                r_done <= 1'b1;
            end
        end
    end

    assign ALUout = r_alu;
    assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu (WIDTH=4).
// Multiply expectations follow SEQ_ALU_MUL_EN when it is defined.
module tb_seq_alu;
    logic       Clock = 1'b0;
    logic       Reset_b = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [2:0] Function = '0;
    logic       start = 1'b0;
    logic       use_reg = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] ALUout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] m_alu;

    seq_alu #(.WIDTH(4)) dut (
        .Clock(Clock), .Reset_b(Reset_b), .A(A), .B(B),
        .Function(Function), .start(start), .use_reg(use_reg),
        .busy(busy), .done(done), .ALUout(ALUout)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [7:0] model(input logic [2:0] f, input logic [3:0] a,
                                         input logic [3:0] b, input logic [7:0] prev);
        int s;
        case (f)
            3'd0: return 8'(int'(a) + int'(b));
            3'd1: return 8'(int'(a) - int'(b) + 256);
            3'd2: begin s = $signed(b); return 8'(s); end
            3'd3: return ({a, b} != 8'h00) ? 8'd1 : 8'd0;
            3'd4: return ({a, b} == 8'hFF) ? 8'd1 : 8'd0;
            3'd5: return 8'(int'(a) * 16 + int'(b));
`ifdef SEQ_ALU_MUL_EN
            3'd6: return 8'(int'(a) * int'(b));
`else
            3'd6: return 8'h00;
`endif
            default: return prev;
        endcase
    endfunction

    task automatic test_reset();
        Reset_b = 1'b0; start = 1'b1; Function = 3'd5; A = 4'h9; B = 4'h6;
        tick();
        n_tests++; if (ALUout !== 8'h00) begin n_fail++; $display("FAIL reset_alu got=%h exp=00", ALUout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        start = 1'b0; Reset_b = 1'b1; m_alu = 8'h00;
        tick();
        n_tests++; if (ALUout !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle got=%h/%b exp=00/0", ALUout, done); end
    endtask

    task automatic test_directed();
        A = 4'hF; B = 4'h1; Function = 3'd0; use_reg = 1'b0; start = 1'b1;
        tick();
        n_tests++; if (ALUout !== 8'h10 || done !== 1'b1) begin n_fail++; $display("FAIL add_carry got=%h/%b exp=10/1", ALUout, done); end
        start = 1'b0; A = 4'h3; use_reg = 1'b1;
        tick();
        n_tests++; if (ALUout !== 8'h10 || done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%h/%b exp=10/0", ALUout, done); end
        start = 1'b1;
        tick();
        n_tests++; if (ALUout !== 8'h03 || done !== 1'b1) begin n_fail++; $display("FAIL acc1 got=%h/%b exp=03/1", ALUout, done); end
        tick();
        n_tests++; if (ALUout !== 8'h06 || done !== 1'b1) begin n_fail++; $display("FAIL acc2 got=%h/%b exp=06/1", ALUout, done); end
        start = 1'b0; use_reg = 1'b0; m_alu = 8'h06;
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL acc_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_random_ops();
        logic [3:0] bop;
        logic [7:0] exp;
        for (int i = 0; i < 60; i++) begin
            A = 4'($urandom); B = 4'($urandom); use_reg = 1'($urandom);
            Function = 3'($urandom);
`ifdef SEQ_ALU_MUL_EN
            if (Function == 3'd6) Function = 3'd7;
`endif
            bop = use_reg ? m_alu[3:0] : B;
            exp = model(Function, A, bop, m_alu);
            start = 1'b1;
            tick();
            m_alu = exp;
            n_tests++; if (ALUout !== exp || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL op f=%0d got=%h/%b/%b exp=%h/1/0", Function, ALUout, done, busy, exp);
            end
            if ($urandom_range(1, 0) == 1) begin
                start = 1'b0; A = 4'($urandom); B = 4'($urandom); Function = 3'($urandom);
                tick();
                n_tests++; if (ALUout !== m_alu || done !== 1'b0) begin
                    n_fail++; $display("FAIL hold got=%h/%b exp=%h/0", ALUout, done, m_alu);
                end
            end
        end
        start = 1'b0;
        tick();
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic ur, input logic poke);
        logic [7:0] exp;
        exp = 8'(int'(a) * int'(ur ? m_alu[3:0] : b));
        A = a; B = b; use_reg = ur; Function = 3'd6; start = 1'b1;
        tick();
        start = 1'b0; A = 4'($urandom); B = 4'($urandom); use_reg = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (busy !== 1'b1 || done !== 1'b0 || ALUout !== m_alu) begin
                n_fail++; $display("FAIL mul_busy c=%0d got=%b/%b/%h exp=1/0/%h", i, busy, done, ALUout, m_alu);
            end
            if (poke && i == 1) begin start = 1'b1; Function = 3'd0; end
            else begin start = 1'b0; Function = 3'd6; end
            tick();
        end
        start = 1'b0;
        m_alu = exp;
        n_tests++; if (ALUout !== exp || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL mul_done got=%h/%b/%b exp=%h/0/1", ALUout, busy, done, exp);
        end
        tick();
        n_tests++; if (ALUout !== exp || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_after got=%h/%b/%b exp=%h/0/0", ALUout, done, busy, exp);
        end
    endtask

    task automatic test_mul();
        run_mul(4'hD, 4'hB, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            run_mul(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_mul_reset();
        A = 4'hD; B = 4'hB; use_reg = 1'b0; Function = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        Reset_b = 1'b0;
        tick();
        m_alu = 8'h00;
        n_tests++; if (ALUout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mul_reset got=%h/%b/%b exp=00/0/0", ALUout, busy, done);
        end
        Reset_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (ALUout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL mul_abandon c=%0d got=%h/%b/%b exp=00/0/0", i, ALUout, busy, done);
            end
        end
    endtask
`else
    task automatic test_nomul();
        A = 4'h3; B = 4'h4; use_reg = 1'b0; Function = 3'd5; start = 1'b1;
        tick();
        A = 4'hD; B = 4'hB; Function = 3'd6;
        tick();
        start = 1'b0;
        n_tests++; if (ALUout !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL nomul got=%h/%b/%b exp=00/1/0", ALUout, done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (busy !== 1'b0 || done !== 1'b0 || ALUout !== 8'h00) begin
                n_fail++; $display("FAIL nomul_idle c=%0d got=%b/%b/%h exp=0/0/00", i, busy, done, ALUout);
            end
        end
        m_alu = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random_ops();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_nomul();
`endif
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
